// File: rtl/iddmm_ctrl_mc.sv
// Sequencer for the word-serial interleaved Montgomery multiplier datapath.
// Round-robin task arbitration, i/j phase counters and skid-buffered result stream.
module iddmm_ctrl_mc #(
  parameter int K      = 256,
  parameter int N_MAX  = 16,
  parameter int NUM_CH = 4,
  parameter int IW     = $clog2(N_MAX),
  parameter int JW     = $clog2(N_MAX + 1),
  parameter int CW     = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    task_req,
  input  logic [NUM_CH*JW-1:0] task_nwords,
  output logic [NUM_CH-1:0]    task_end,
  output logic                 busy,
  input  logic                 abort,
  output logic                 fifo_flush,
  output logic [IW-1:0]        rd_addr_i,
  output logic [JW-1:0]        rd_addr_j,
  output logic [IW-1:0]        i_cnt,
  output logic [JW-1:0]        j_cnt,
  output logic                 loop_en,
  output logic                 q_en,
  input  logic                 cal_done,
  input  logic                 cal_sign,
  output logic                 fifo_rd_en,
  input  logic [K-1:0]         fifo_rd_data_a,
  input  logic [K-1:0]         fifo_rd_data_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K-1:0]         out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LOOP,
    S_WAIT,
    S_OUT
  } state_t;

  localparam int            CW1    = CW + 1;
  localparam logic [CW:0]   NCH    = CW1'(NUM_CH);
  localparam logic [CW-1:0] LASTCH = CW'(NUM_CH - 1);
  localparam logic [JW-1:0] TWO    = JW'(2);
  localparam logic [JW-1:0] NMAXW  = JW'(N_MAX);

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [JW-1:0] n_q, n_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [CW-1:0] rr_q, rr_d;
  logic          sign_q, sign_d;
  logic [JW-1:0] pop_q, pop_d;
  logic [JW-1:0] beat_q, beat_d;
  logic          inflt_q, inflt_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [K-1:0]  b0_q, b0_d;
  logic [K-1:0]  b1_q, b1_d;
  logic [IW-1:0] i_cnt_q;
  logic [JW-1:0] j_cnt_q;
  logic          loop_en_q, q_en_q;

  logic [JW-1:0] nw_arr [NUM_CH];
  logic          gnt_vld;
  logic [CW-1:0] gnt_ch;
  logic [CW:0]   idx_w;
  logic [JW-1:0] nw_raw, nw_clamp;
  logic          last_ij;
  logic          in_out, rd_en, vld, acc, last_w, done_w;
  logic [K-1:0]  push_w;
  logic [NUM_CH-1:0] te_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_nw
    assign nw_arr[c] = task_nwords[c*JW +: JW];
  end

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx_w   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_w = {1'b0, rr_q} + CW1'(k);
      if (idx_w >= NCH) idx_w = idx_w - NCH;
      if (!gnt_vld && task_req[idx_w[CW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx_w[CW-1:0];
      end
    end
  end

  always_comb begin
    nw_raw   = nw_arr[gnt_ch];
    nw_clamp = nw_raw;
    if (nw_raw < TWO)   nw_clamp = TWO;
    if (nw_raw > NMAXW) nw_clamp = NMAXW;
  end

  assign last_ij = (JW'(i_q) == n_q - JW'(1)) && (j_q == n_q);

  // Pop only while buffered plus in-flight words leave room in the skid buffer.
  assign in_out = (state_q == S_OUT) && !abort;
  assign rd_en  = in_out && (pop_q != n_q)
                  && ((bcnt_q + {1'b0, inflt_q}) < 2'd2);
  assign vld    = in_out && (bcnt_q != 2'd0);
  assign acc    = vld && out_ready;
  assign last_w = vld && (beat_q == n_q - JW'(1));
  assign done_w = acc && last_w;
  assign push_w = sign_q ? fifo_rd_data_sub : fifo_rd_data_a;

  always_comb begin
    te_w       = '0;
    te_w[ch_q] = done_w;
  end

  always_comb begin
    b0_d    = b0_q;
    b1_d    = b1_q;
    bcnt_d  = bcnt_q;
    inflt_d = rd_en;
    if (acc) begin
      b0_d   = b1_q;
      bcnt_d = bcnt_q - 2'd1;
    end
    if (inflt_q) begin
      if (bcnt_d == 2'd0) b0_d = push_w;
      else                b1_d = push_w;
      bcnt_d = bcnt_d + 2'd1;
    end
    if (abort && state_q != S_IDLE) begin
      bcnt_d  = 2'd0;
      inflt_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    n_d     = n_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    sign_d  = sign_q;
    pop_d   = pop_q;
    beat_d  = beat_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          state_d = S_PRE;
          ch_d    = gnt_ch;
          n_d     = nw_clamp;
          i_d     = '0;
          j_d     = '0;
          rr_d    = (gnt_ch == LASTCH) ? '0 : gnt_ch + CW'(1);
        end
      end
      S_PRE, S_LOOP: begin
        if (last_ij) begin
          state_d = (state_q == S_PRE) ? S_LOOP : S_WAIT;
          i_d     = '0;
          j_d     = '0;
        end else if (j_q == n_q) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_WAIT: begin
        if (cal_done) begin
          state_d = S_OUT;
          sign_d  = cal_sign;
          pop_d   = '0;
          beat_d  = '0;
        end
      end
      S_OUT: begin
        pop_d  = pop_q + JW'(rd_en);
        beat_d = beat_q + JW'(acc);
        if (done_w) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      i_d     = '0;
      j_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      n_q       <= '0;
      ch_q      <= '0;
      rr_q      <= '0;
      sign_q    <= 1'b0;
      pop_q     <= '0;
      beat_q    <= '0;
      inflt_q   <= 1'b0;
      bcnt_q    <= 2'd0;
      b0_q      <= '0;
      b1_q      <= '0;
      i_cnt_q   <= '0;
      j_cnt_q   <= '0;
      loop_en_q <= 1'b0;
      q_en_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      n_q       <= n_d;
      ch_q      <= ch_d;
      rr_q      <= rr_d;
      sign_q    <= sign_d;
      pop_q     <= pop_d;
      beat_q    <= beat_d;
      inflt_q   <= inflt_d;
      bcnt_q    <= bcnt_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      i_cnt_q   <= i_q;
      j_cnt_q   <= j_q;
      loop_en_q <= (state_q == S_LOOP);
      q_en_q    <= (state_q == S_PRE);
    end
  end

  assign task_end   = te_w;
  assign busy       = (state_q != S_IDLE);
  assign fifo_flush = abort && (state_q != S_IDLE);
  assign rd_addr_i  = i_q;
  assign rd_addr_j  = j_q;
  assign i_cnt      = i_cnt_q;
  assign j_cnt      = j_cnt_q;
  assign loop_en    = loop_en_q;
  assign q_en       = q_en_q;
  assign fifo_rd_en = rd_en;
  assign out_valid  = vld;
  assign out_data   = b0_q;
  assign out_ch     = ch_q;
  assign out_last   = last_w;

endmodule
